pong_ball_engine: RTL and testbench
===================================

// Module: pong_ball_engine
// PURPOSE
//  Next-generation Pong ball controller: moves the ball on the divided game grid and bounces it
//  off the top/bottom walls and both paddles. Detects misses, emits one-cycle score pulses and
//  runs a serve/score state machine. Ball speeds up on every paddle hit.
//  Sits between the paddle controllers and the score/draw logic of the Pong top level.
// PARAMETERS
//  c_GAME_WIDTH     40       grid columns; P1 paddle column 0, P2 paddle column c_GAME_WIDTH-1
//  c_GAME_HEIGHT    30       grid rows
//  c_COORD_W        6        width of all X/Y coordinate ports
//  c_PADDLE_HEIGHT  6        paddle length in rows, measured from paddle top Y downward
//  c_SPEED_INIT     1250000  clocks per ball step after each serve
//  c_SPEED_MIN      250000   fastest allowed period (floor)
//  c_SPEED_STEP     62500    period decrement applied per paddle hit
//  c_SERVE_TICKS    20       ball steps (at current period) spent waiting in SERVE and in SCORE
// PORTS
//  i_Clk              in   1          system clock
//  i_Rst              in   1          synchronous reset, active-high
//  i_Game_Active      in   1          0 forces IDLE; 0->1 starts a serve
//  i_Paddle_Y_P1      in   c_COORD_W  top row of P1 paddle
//  i_Paddle_Y_P2      in   c_COORD_W  top row of P2 paddle
//  i_Col_Count_Div    in   c_COORD_W  current pixel column, in grid units
//  i_Row_Count_Div    in   c_COORD_W  current pixel row, in grid units
//  o_Draw_Ball        out  1          1 when the pixel is at the ball cell (registered)
//  o_Ball_X           out  c_COORD_W  ball column
//  o_Ball_Y           out  c_COORD_W  ball row
//  o_P1_Score_Pulse   out  1          one-cycle pulse: P1 scored (P2 missed)
//  o_P2_Score_Pulse   out  1          one-cycle pulse: P2 scored (P1 missed)
//  o_State            out  2          FSM state (IDLE=0, SERVE=1, PLAY=2, SCORE=3)
// BEHAVIOUR
//  Reset (priority over everything): State=IDLE; Ball=(W/2,H/2); dx=right, dy=down;
//   period=c_SPEED_INIT; tick and wait counters=0; pulses=0; o_Draw_Ball=0.
//  Tick: the counter counts 0..period-1. At period-1 it asserts tick for one cycle and returns to 0.
//   It counts only in SERVE/PLAY/SCORE and is cleared in IDLE.
//  i_Game_Active=0 in any state -> next cycle IDLE, with the same values as reset except the pulses.
//  IDLE -> SERVE when i_Game_Active=1.
//  SERVE: ball held at (W/2,H/2), period=c_SPEED_INIT. After c_SERVE_TICKS ticks -> PLAY.
//   The serve goes toward the player who lost the last point; first serve goes right. dy keeps its value.
//  PLAY, on each tick (X and Y both update on the same tick):
//   Y: down and Y==H-1 -> dy=up, Y-1; up and Y==0 -> dy=down, Y+1; else Y +/-1.
//   X left at X==1: P1 hit when P1_Y <= Y <= P1_Y+c_PADDLE_HEIGHT-1.
//    Use the pre-step Y; compute in c_COORD_W+1 bits so there is no wrap.
//    Hit -> dx=right, X=2, period=max(period-c_SPEED_STEP, c_SPEED_MIN), saturating with no underflow.
//    Miss -> X=0, o_P2_Score_Pulse=1 for exactly 1 cycle, State=SCORE.
//   X right at X==W-2: same rule mirrored with P2 paddle.
//    Hit -> X=W-3, dx=left. Miss -> X=W-1, o_P1_Score_Pulse.
//   Otherwise X +/-1. A corner case (wall bounce and paddle hit) applies both reversals.
//  SCORE: ball frozen at the miss cell for c_SERVE_TICKS ticks, then recentred -> SERVE.
//  Paddle inputs are sampled only on PLAY ticks. Paddle values outside the grid simply never hit.
//  o_Draw_Ball <= (Col==X && Row==Y) every cycle in all states. Latency: 1 clock.
//  Only one score pulse can be high at a time. Neither pulse ever fires outside PLAY.
// STRUCTURE
//  Package pong_ball_pkg: state encoding (2 bits), dx/dy encoding (1=right/down),
//   and centre-coordinate constants derived from W/H.
//  Sub-module pong_tick_gen: programmable-period counter.
//   Inputs: clk, rst, enable, period. Output: tick.
//  The top level holds the FSM, direction registers, collision compare and speed register.
// TESTING (bench params: W=16, H=8, c_PADDLE_HEIGHT=3, SPEED_INIT=4, MIN=2, STEP=1, SERVE_TICKS=2)
//  1 Reset mid-PLAY: assert i_Rst 1 cycle -> State=0, Ball=(8,4), pulses 0 next cycle.
//  2 Game_Active 0->1 -> SERVE; after 2 ticks (8 clks) -> PLAY, X steps 8->9 every 4 clks.
//  3 Wall bounce: Y=7 moving down on tick -> Y=6, dy=up; Y=0 moving up -> Y=1.
//  4 Hit: ball X=14 moving right, P2_Y=3, Y=5 -> X=13, dx=left, period 4->3.
//    Three more hits -> period stays at 2.
//  5 Miss: ball X=1 moving left, P1_Y=0, Y=5 -> X=0, o_P2_Score_Pulse high 1 clk, State=3.
//    After 2 ticks -> SERVE at (8,4), next serve goes left.
//  6 Draw: Col=X and Row=Y -> o_Draw_Ball=1 exactly one clock later. Mismatch -> 0.
//    Drop i_Game_Active during SCORE -> IDLE next cycle, no pulse.

Source files
------------

// File: rtl/pong_ball_pkg.sv
// Shared definitions for the Pong ball engine.
//   state_t      : FSM state encoding (IDLE=0, SERVE=1, PLAY=2, SCORE=3)
//   DIR_*        : direction bit encoding (1 = right / down, 0 = left / up)
//   centre_of()  : centre cell of a grid axis, used to derive the serve position
package pong_ball_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_SCORE = 2'd3
    } state_t;

    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;
    localparam logic DIR_UP    = 1'b0;

    function automatic int centre_of(input int extent);
        return extent / 2;
    endfunction

endpackage

// File: rtl/pong_tick_gen.sv
// Programmable-period step timer for the ball.
//   clk    : clock
//   rst    : synchronous reset, active-high
//   enable : counter runs while high, held at zero while low
//   period : clocks per tick (counts 0..period-1)
//   tick   : high for the one cycle in which the counter sits at period-1
module pong_tick_gen #(
    parameter int c_PERIOD_W = 21
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [c_PERIOD_W-1:0] period,
    output logic                  tick
);

    localparam logic [c_PERIOD_W-1:0] c_ONE = c_PERIOD_W'(1);

    logic [c_PERIOD_W-1:0] cnt_q;
    logic [c_PERIOD_W-1:0] cnt_d;

    always_comb begin
        // '>=' rather than '==' so a period that shrinks below the current
        // count can never strand the counter past its terminal value.
        tick  = enable && (cnt_q >= (period - c_ONE));
        cnt_d = '0;
        if (enable && !tick) begin
            cnt_d = cnt_q + c_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pong_ball_engine.sv
// Pong ball controller: moves the ball on the divided grid, bounces off walls
// and paddles, detects misses and sequences serve / play / score.
//   i_Clk, i_Rst                 : clock, synchronous active-high reset
//   i_Game_Active                : 0 forces IDLE, 1 lets a serve start
//   i_Paddle_Y_P1/P2             : paddle top rows (sampled on PLAY ticks only)
//   i_Col_Count_Div/Row_Count_Div: current pixel position in grid units
//   o_Draw_Ball                  : pixel is on the ball cell (1 clock latency)
//   o_Ball_X/Y                   : ball cell
//   o_P1/P2_Score_Pulse          : one-cycle score strobes
//   o_State                      : FSM state
module pong_ball_engine
    import pong_ball_pkg::*;
#(
    parameter int c_GAME_WIDTH    = 40,
    parameter int c_GAME_HEIGHT   = 30,
    parameter int c_COORD_W       = 6,
    parameter int c_PADDLE_HEIGHT = 6,
    parameter int c_SPEED_INIT    = 1250000,
    parameter int c_SPEED_MIN     = 250000,
    parameter int c_SPEED_STEP    = 62500,
    parameter int c_SERVE_TICKS   = 20
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_Game_Active,
    input  logic [c_COORD_W-1:0] i_Paddle_Y_P1,
    input  logic [c_COORD_W-1:0] i_Paddle_Y_P2,
    input  logic [c_COORD_W-1:0] i_Col_Count_Div,
    input  logic [c_COORD_W-1:0] i_Row_Count_Div,
    output logic                 o_Draw_Ball,
    output logic [c_COORD_W-1:0] o_Ball_X,
    output logic [c_COORD_W-1:0] o_Ball_Y,
    output logic                 o_P1_Score_Pulse,
    output logic                 o_P2_Score_Pulse,
    output logic [1:0]           o_State
);

    localparam int c_PERIOD_W = $clog2(c_SPEED_INIT + 1);
    localparam int c_WAIT_W   = (c_SERVE_TICKS > 1) ? $clog2(c_SERVE_TICKS) : 1;

    localparam logic [c_COORD_W-1:0] c_ONE       = c_COORD_W'(1);
    localparam logic [c_COORD_W-1:0] c_CENTRE_X  = c_COORD_W'(centre_of(c_GAME_WIDTH));
    localparam logic [c_COORD_W-1:0] c_CENTRE_Y  = c_COORD_W'(centre_of(c_GAME_HEIGHT));
    localparam logic [c_COORD_W-1:0] c_Y_BOTTOM  = c_COORD_W'(c_GAME_HEIGHT - 1);
    localparam logic [c_COORD_W-1:0] c_X_P1_FACE = c_COORD_W'(1);
    localparam logic [c_COORD_W-1:0] c_X_P1_BNC  = c_COORD_W'(2);
    localparam logic [c_COORD_W-1:0] c_X_P2_FACE = c_COORD_W'(c_GAME_WIDTH - 2);
    localparam logic [c_COORD_W-1:0] c_X_P2_BNC  = c_COORD_W'(c_GAME_WIDTH - 3);
    localparam logic [c_COORD_W-1:0] c_X_P2_GOAL = c_COORD_W'(c_GAME_WIDTH - 1);
    localparam logic [c_COORD_W:0]   c_PAD_SPAN  = (c_COORD_W+1)'(c_PADDLE_HEIGHT - 1);

    localparam logic [c_PERIOD_W-1:0] c_PERIOD_INIT = c_PERIOD_W'(c_SPEED_INIT);
    localparam logic [c_PERIOD_W-1:0] c_PERIOD_MIN  = c_PERIOD_W'(c_SPEED_MIN);
    localparam logic [c_PERIOD_W-1:0] c_PERIOD_STEP = c_PERIOD_W'(c_SPEED_STEP);
    localparam logic [c_PERIOD_W:0]   c_DEC_FLOOR   = (c_PERIOD_W+1)'(c_SPEED_MIN + c_SPEED_STEP);
    localparam logic [c_WAIT_W-1:0]   c_WAIT_LAST   = c_WAIT_W'(c_SERVE_TICKS - 1);
    localparam logic [c_WAIT_W-1:0]   c_WAIT_ONE    = c_WAIT_W'(1);

    state_t                state_q, state_d;
    logic [c_COORD_W-1:0]  x_q, x_d, y_q, y_d;
    logic                  dx_q, dx_d, dy_q, dy_d;
    logic [c_PERIOD_W-1:0] period_q, period_d;
    logic [c_WAIT_W-1:0]   wait_q, wait_d;
    logic                  p1_pulse_q, p1_pulse_d, p2_pulse_q, p2_pulse_d;
    logic                  draw_q, draw_d;

    logic                  tick, tick_en;
    logic [c_COORD_W:0]    y_ext, p1_top, p1_bot, p2_top, p2_bot;
    logic                  p1_hit, p2_hit;
    logic [c_PERIOD_W-1:0] period_fast;

    // Gating with i_Game_Active clears the counter on the same edge the FSM
    // drops to IDLE, so an abort leaves the timer exactly as reset would.
    assign tick_en = (state_q != ST_IDLE) && i_Game_Active;

    pong_tick_gen #(
        .c_PERIOD_W (c_PERIOD_W)
    ) u_tick_gen (
        .clk    (i_Clk),
        .rst    (i_Rst),
        .enable (tick_en),
        .period (period_q),
        .tick   (tick)
    );

    // Paddle window compared one bit wider so a paddle near the top of the
    // coordinate range cannot wrap its bottom edge back to row 0.
    assign y_ext  = {1'b0, y_q};
    assign p1_top = {1'b0, i_Paddle_Y_P1};
    assign p2_top = {1'b0, i_Paddle_Y_P2};
    assign p1_bot = p1_top + c_PAD_SPAN;
    assign p2_bot = p2_top + c_PAD_SPAN;
    assign p1_hit = (p1_top <= y_ext) && (y_ext <= p1_bot);
    assign p2_hit = (p2_top <= y_ext) && (y_ext <= p2_bot);

    assign period_fast = ({1'b0, period_q} >= c_DEC_FLOOR) ? (period_q - c_PERIOD_STEP)
                                                           : c_PERIOD_MIN;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        period_d   = period_q;
        wait_d     = wait_q;
        p1_pulse_d = 1'b0;
        p2_pulse_d = 1'b0;
        draw_d     = (i_Col_Count_Div == x_q) && (i_Row_Count_Div == y_q);

        if (!i_Game_Active) begin
            state_d  = ST_IDLE;
            x_d      = c_CENTRE_X;
            y_d      = c_CENTRE_Y;
            dx_d     = DIR_RIGHT;
            dy_d     = DIR_DOWN;
            period_d = c_PERIOD_INIT;
            wait_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SERVE;
                end
                ST_SERVE: begin
                    // dx is left untouched: it still points at the player who
                    // lost the last point (or right after reset).
                    x_d      = c_CENTRE_X;
                    y_d      = c_CENTRE_Y;
                    period_d = c_PERIOD_INIT;
                    if (tick) begin
                        if (wait_q == c_WAIT_LAST) begin
                            wait_d  = '0;
                            state_d = ST_PLAY;
                        end else begin
                            wait_d = wait_q + c_WAIT_ONE;
                        end
                    end
                end
                ST_PLAY: begin
                    if (tick) begin
                        if (dy_q == DIR_DOWN && y_q == c_Y_BOTTOM) begin
                            dy_d = DIR_UP;
                            y_d  = y_q - c_ONE;
                        end else if (dy_q == DIR_UP && y_q == '0) begin
                            dy_d = DIR_DOWN;
                            y_d  = y_q + c_ONE;
                        end else if (dy_q == DIR_DOWN) begin
                            y_d = y_q + c_ONE;
                        end else begin
                            y_d = y_q - c_ONE;
                        end

                        if (dx_q == DIR_LEFT && x_q == c_X_P1_FACE) begin
                            if (p1_hit) begin
                                dx_d     = DIR_RIGHT;
                                x_d      = c_X_P1_BNC;
                                period_d = period_fast;
                            end else begin
                                x_d        = '0;
                                p2_pulse_d = 1'b1;
                                state_d    = ST_SCORE;
                            end
                        end else if (dx_q == DIR_RIGHT && x_q == c_X_P2_FACE) begin
                            if (p2_hit) begin
                                dx_d     = DIR_LEFT;
                                x_d      = c_X_P2_BNC;
                                period_d = period_fast;
                            end else begin
                                x_d        = c_X_P2_GOAL;
                                p1_pulse_d = 1'b1;
                                state_d    = ST_SCORE;
                            end
                        end else if (dx_q == DIR_RIGHT) begin
                            x_d = x_q + c_ONE;
                        end else begin
                            x_d = x_q - c_ONE;
                        end
                    end
                end
                ST_SCORE: begin
                    if (tick) begin
                        if (wait_q == c_WAIT_LAST) begin
                            wait_d   = '0;
                            x_d      = c_CENTRE_X;
                            y_d      = c_CENTRE_Y;
                            period_d = c_PERIOD_INIT;
                            state_d  = ST_SERVE;
                        end else begin
                            wait_d = wait_q + c_WAIT_ONE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q    <= ST_IDLE;
            x_q        <= c_CENTRE_X;
            y_q        <= c_CENTRE_Y;
            dx_q       <= DIR_RIGHT;
            dy_q       <= DIR_DOWN;
            period_q   <= c_PERIOD_INIT;
            wait_q     <= '0;
            p1_pulse_q <= 1'b0;
            p2_pulse_q <= 1'b0;
            draw_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            period_q   <= period_d;
            wait_q     <= wait_d;
            p1_pulse_q <= p1_pulse_d;
            p2_pulse_q <= p2_pulse_d;
            draw_q     <= draw_d;
        end
    end

    assign o_Draw_Ball      = draw_q;
    assign o_Ball_X         = x_q;
    assign o_Ball_Y         = y_q;
    assign o_P1_Score_Pulse = p1_pulse_q;
    assign o_P2_Score_Pulse = p2_pulse_q;
    assign o_State          = state_q;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Directed bench for pong_ball_engine on a 16x8 grid, paddle height 3,
// period 4 -> floor 2 in steps of 1, 2 ticks of serve/score wait.
module tb_pong_ball_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       active;
    logic [5:0] p1_y, p2_y, col, row;
    logic       draw, p1_pulse, p2_pulse;
    logic [5:0] bx, by;
    logic [1:0] st;

    int n_cmp = 0;
    int n_err = 0;
    int clks;

    // Hand-traced trajectory after a fresh serve to the right with dy=down:
    // hits at moves 7 (P2), 20 (P1), 33 (P2), 46 (P1 corner), miss at 59 (P2).
    int seg_x [59] = '{ 9,10,11,12,13,14,13,12,11,10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 2,
                        3, 4, 5, 6, 7, 8, 9,10,11,12,13,14,13,12,11,10, 9, 8, 7, 6,
                        5, 4, 3, 2, 1, 2, 3, 4, 5, 6, 7, 8, 9,10,11,12,13,14,15};
    int seg_y [59] = '{ 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4,
                        3, 2, 1, 0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2,
                        3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2, 3, 4, 5, 6, 7};
    int s3_x [8] = '{7, 6, 5, 4, 3, 2, 1, 0};
    int s3_y [8] = '{3, 2, 1, 0, 1, 2, 3, 4};

    pong_ball_engine #(
        .c_GAME_WIDTH    (16),
        .c_GAME_HEIGHT   (8),
        .c_COORD_W       (6),
        .c_PADDLE_HEIGHT (3),
        .c_SPEED_INIT    (4),
        .c_SPEED_MIN     (2),
        .c_SPEED_STEP    (1),
        .c_SERVE_TICKS   (2)
    ) dut (
        .i_Clk            (clk),
        .i_Rst            (rst),
        .i_Game_Active    (active),
        .i_Paddle_Y_P1    (p1_y),
        .i_Paddle_Y_P2    (p2_y),
        .i_Col_Count_Div  (col),
        .i_Row_Count_Div  (row),
        .o_Draw_Ball      (draw),
        .o_Ball_X         (bx),
        .o_Ball_Y         (by),
        .o_P1_Score_Pulse (p1_pulse),
        .o_P2_Score_Pulse (p2_pulse),
        .o_State          (st)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Clocks until the ball cell changes (bounded).
    task automatic wait_move(output int n);
        logic [5:0] px, py;
        px = bx;
        py = by;
        n  = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bx == px && by == py && n < 64);
    endtask

    // Clocks until o_State reaches the target (bounded).
    task automatic wait_state(input logic [1:0] target, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (st !== target && n < 64);
    endtask

    task automatic check_ball(input string tag, input int ex, input int ey);
        check({tag, "_x"}, 32'(bx), ex);
        check({tag, "_y"}, 32'(by), ey);
    endtask

    task automatic run_seg(input int n_moves);
        int n;
        int exp_clks;
        for (int i = 0; i < n_moves; i++) begin
            if (i == 6)  p2_y = 6'd3;
            if (i == 19) p1_y = 6'd4;
            if (i == 32) p2_y = 6'd5;
            if (i == 45) p1_y = 6'd5;
            if (i == 58) p2_y = 6'd0;
            exp_clks = (i < 7) ? 4 : ((i < 20) ? 3 : 2);
            wait_move(n);
            check("move_clks", n, exp_clks);
            check_ball("move", seg_x[i], seg_y[i]);
            check("move_pulses", 32'({p1_pulse, p2_pulse}), (i == 58) ? 2 : 0);
            check("move_state", 32'(st), (i == 58) ? 3 : 2);
            $display("move %0d: ball=(%0d,%0d) after %0d clks state=%0d", i + 1, bx, by, n, st);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        active = 1'b0;
        p1_y   = 6'd4;
        p2_y   = 6'd3;
        col    = 6'd8;
        row    = 6'd4;
        repeat (2) @(negedge clk);
        check("rst_state", 32'(st), 0);
        check_ball("rst", 8, 4);
        check("rst_pulses", 32'({p1_pulse, p2_pulse}), 0);
        check("rst_draw", 32'(draw), 0);
        $display("reset: state=%0d ball=(%0d,%0d)", st, bx, by);

        // Draw comparator, 1 clock latency, ball parked at (8,4) in IDLE.
        rst = 1'b0;
        @(negedge clk);
        check("draw_hit", 32'(draw), 1);
        check("idle_state", 32'(st), 0);
        col = 6'd9;
        @(negedge clk);
        check("draw_col_miss", 32'(draw), 0);
        col = 6'd8;
        row = 6'd5;
        @(negedge clk);
        check("draw_row_miss", 32'(draw), 0);
        row = 6'd4;
        @(negedge clk);
        check("draw_hit_again", 32'(draw), 1);
        $display("draw: col=%0d row=%0d draw=%0d", col, row, draw);
        col = 6'd0;
        row = 6'd0;

        // Serve timing and first steps.
        active = 1'b1;
        wait_state(2'd1, clks);
        check("to_serve_clks", clks, 1);
        wait_state(2'd2, clks);
        check("serve_len_clks", clks, 8);
        check_ball("play_start", 8, 4);
        wait_move(clks);
        check("first_step_clks", clks, 4);
        check_ball("first_step", 9, 5);
        wait_move(clks);
        check("second_step_clks", clks, 4);
        check_ball("second_step", 10, 6);
        $display("play: ball=(%0d,%0d) state=%0d", bx, by, st);

        // Reset in the middle of PLAY.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_state", 32'(st), 0);
        check_ball("midrst", 8, 4);
        check("midrst_pulses", 32'({p1_pulse, p2_pulse}), 0);
        $display("mid-play reset: state=%0d ball=(%0d,%0d)", st, bx, by);

        wait_state(2'd1, clks);
        check("reserve_clks", clks, 1);
        wait_state(2'd2, clks);
        check("reserve_len_clks", clks, 8);

        // Long rally: walls, four hits with speed-up to the floor, P2 miss.
        run_seg(59);
        @(negedge clk);
        check("p1_pulse_width", 32'({p1_pulse, p2_pulse}), 0);
        check_ball("score_frozen", 15, 7);
        wait_state(2'd1, clks);
        check("score1_clks", clks, 3);
        check_ball("score1_recentre", 8, 4);
        wait_state(2'd2, clks);
        check("serve2_clks", clks, 8);
        $display("serve after P2 miss: ball=(%0d,%0d) state=%0d", bx, by, st);

        // Second rally: P2 hit (period 3), then P1 misses at X=1, Y=5.
        run_seg(19);
        p1_y = 6'd0;
        wait_move(clks);
        check("p1_miss_clks", clks, 3);
        check_ball("p1_miss", 0, 4);
        check("p1_miss_pulses", 32'({p1_pulse, p2_pulse}), 1);
        check("p1_miss_state", 32'(st), 3);
        $display("P1 miss: ball=(%0d,%0d) pulses=%0d%0d state=%0d", bx, by, p1_pulse, p2_pulse, st);
        @(negedge clk);
        check("p2_pulse_width", 32'({p1_pulse, p2_pulse}), 0);
        check_ball("score2_frozen", 0, 4);
        wait_state(2'd1, clks);
        check("score2_clks", clks, 5);
        check_ball("score2_recentre", 8, 4);
        wait_state(2'd2, clks);
        check("serve3_clks", clks, 8);

        // Serve goes left toward P1; off-grid paddle never hits.
        for (int i = 0; i < 8; i++) begin
            if (i == 7) p1_y = 6'd62;
            wait_move(clks);
            check("left_clks", clks, 4);
            check_ball("left", s3_x[i], s3_y[i]);
            check("left_pulses", 32'({p1_pulse, p2_pulse}), (i == 7) ? 1 : 0);
            $display("left move %0d: ball=(%0d,%0d) state=%0d", i + 1, bx, by, st);
        end
        check("offgrid_state", 32'(st), 3);

        // Abort during SCORE.
        @(negedge clk);
        active = 1'b0;
        @(negedge clk);
        check("abort_state", 32'(st), 0);
        check_ball("abort", 8, 4);
        check("abort_pulses", 32'({p1_pulse, p2_pulse}), 0);
        @(negedge clk);
        check("abort_idle_hold", 32'(st), 0);
        check("abort_no_pulse", 32'({p1_pulse, p2_pulse}), 0);
        $display("abort: state=%0d ball=(%0d,%0d)", st, bx, by);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
